// File: rtl/dm_copy_engine.sv
// DataMem copy/fill master: moves or fills len 16-bit words, copying descending
// when the destination overlaps the tail of the source so no word is overwritten before it is read.
module dm_copy_engine #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    input  logic [DW-1:0] dmReDat,
    output logic [AW-1:0] dmReDat_addr,
    output logic [DW-1:0] dmWrDat,
    output logic [AW-1:0] dmWrDat_addr,
    output logic          dmWrite
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_e;

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic          desc_q, desc_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   count_q, count_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          we_q, we_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_dat_q, wr_dat_d;

    logic [AW:0]   src_end;
    logic [AW:0]   len_m1;
    logic [AW-1:0] last_ofs;
    logic          overlap;

    // Overlap is judged on unwrapped addresses; the walk itself wraps modulo 2^AW.
    assign src_end  = {1'b0, src_addr} + len;
    assign len_m1   = len - (AW+1)'(1);
    assign last_ofs = len_m1[AW-1:0];
    assign overlap  = !mode && (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        mode_d  = mode_q;
        desc_d  = desc_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    desc_d  = overlap;
                    count_d = len;
                    src_d   = overlap ? src_addr + last_ofs : src_addr;
                    dst_d   = overlap ? dst_addr + last_ofs : dst_addr;
                    if (len == '0)  state_d = FIN;
                    else if (mode)  state_d = WR;
                    else            state_d = RD;
                end
            end
            RD: state_d = WR;
            WR: begin
                count_d = count_q - (AW+1)'(1);
                src_d   = desc_q ? src_q - 1'b1 : src_q + 1'b1;
                dst_d   = desc_q ? dst_q - 1'b1 : dst_q + 1'b1;
                if (count_q == (AW+1)'(1)) state_d = FIN;
                else if (mode_q)           state_d = WR;
                else                       state_d = RD;
            end
            FIN: state_d = IDLE;
        endcase

        // Outputs are precomputed from the next state so they can all be registered.
        busy_d    = (state_d == RD) || (state_d == WR);
        done_d    = (state_d == FIN);
        we_d      = (state_d == WR);
        rd_addr_d = (state_d == RD) ? src_d : rd_addr_q;
        wr_addr_d = (state_d == WR) ? dst_d : wr_addr_q;
        wr_dat_d  = wr_dat_q;
        if (state_d == WR && state_q == RD)   wr_dat_d = dmReDat;
        if (state_d == WR && state_q == IDLE) wr_dat_d = fill_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            desc_q    <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            mode_q    <= mode_d;
            desc_q    <= desc_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign dmWrite      = we_q;
    assign dmReDat_addr = rd_addr_q;
    assign dmWrDat_addr = wr_addr_q;
    assign dmWrDat      = wr_dat_q;

endmodule

// File: tb/tb_dm_copy_engine.sv
// Bench for dm_copy_engine: a behavioural DataMem plus a sequential word-move model
// predicts every write, the done latency, busy length and the final memory image.
module tb_dm_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [10:0] len;
    logic [15:0] fill_val;
    logic        busy;
    logic        done;
    logic [15:0] dmReDat;
    logic [9:0]  dmReDat_addr;
    logic [15:0] dmWrDat;
    logic [9:0]  dmWrDat_addr;
    logic        dmWrite;

    logic [15:0] mem     [1024];
    logic [15:0] exp_mem [1024];
    int          exp_wa[$];
    int          exp_wd[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    dm_copy_engine #(.AW(10), .DW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .fill_val     (fill_val),
        .busy         (busy),
        .done         (done),
        .dmReDat      (dmReDat),
        .dmReDat_addr (dmReDat_addr),
        .dmWrDat      (dmWrDat),
        .dmWrDat_addr (dmWrDat_addr),
        .dmWrite      (dmWrite)
    );

    assign dmReDat = mem[dmReDat_addr];

    always @(posedge clk) begin
        if (dmWrite) mem[dmWrDat_addr] <= dmWrDat;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Predicts a transfer word by word; abort_at >= 0 applies only that many writes.
    task automatic run_xfer(input logic m, input logic [9:0] s, input logic [9:0] d,
                            input logic [10:0] l, input logic [15:0] f,
                            input int abort_at, input bit stray);
        int  n_apply, lat, done_at, busy_n, wr_n, bad, k;
        bit  desc, aborted;
        logic [9:0]  sa, da;
        logic [15:0] v;

        exp_wa.delete();
        exp_wd.delete();
        for (int i = 0; i < 1024; i++) exp_mem[i] = mem[i];
        desc    = (m == 1'b0) && (int'(d) > int'(s)) && (int'(d) < int'(s) + int'(l));
        n_apply = (abort_at >= 0) ? abort_at : int'(l);
        for (int i = 0; i < int'(l); i++) begin
            k  = desc ? int'(l) - 1 - i : i;
            sa = 10'((int'(s) + k) % 1024);
            da = 10'((int'(d) + k) % 1024);
            v  = m ? f : exp_mem[sa];
            exp_wa.push_back(int'(da));
            exp_wd.push_back(int'(v));
            if (i < n_apply) exp_mem[da] = v;
        end

        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f; start = 1'b1;
        done_at = -1; busy_n = 0; wr_n = 0; aborted = 1'b0;
        for (int cyc = 1; cyc <= 2100; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (busy) busy_n++;
            if (dmWrite) begin
                if (wr_n == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check("abort_we", int'(dmWrite), 0);
                    check("abort_busy", int'(busy), 0);
                    aborted = 1'b1;
                    break;
                end
                if (wr_n < exp_wa.size()) begin
                    check("wr_addr", int'(dmWrDat_addr), exp_wa[wr_n]);
                    check("wr_data", int'(dmWrDat), exp_wd[wr_n]);
                end else begin
                    check("extra_write", wr_n, exp_wa.size());
                end
                wr_n++;
            end
            if (stray && cyc == 2) begin
                start = 1'b1; mode = ~m; src_addr = 10'($urandom);
                dst_addr = 10'($urandom); len = 11'd5; fill_val = 16'hdead;
            end
            if (stray && cyc == 3) start = 1'b0;
            if (done) begin
                done_at = cyc;
                break;
            end
        end

        if (abort_at >= 0) begin
            check("abort_hit", int'(aborted), 1);
            repeat (3) begin
                @(negedge clk);
                check("abort_no_done", int'(done), 0);
            end
            rst = 1'b0;
        end else begin
            lat = (l == 0) ? 1 : (m ? int'(l) + 1 : 2 * int'(l) + 1);
            check("done_lat", done_at, lat);
            check("busy_cycles", busy_n, lat - 1);
            check("wr_count", wr_n, int'(l));
            @(negedge clk);
            start = 1'b0;
            check("done_pulse", int'(done), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_we", int'(dmWrite), 0);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) bad++;
        check("mem_image", bad, 0);
    endtask

    initial begin
        logic        rm;
        logic [9:0]  rs, rd;
        logic [10:0] rl;

        rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_val = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(dmWrite), 0);
        check("rst_rd_addr", int'(dmReDat_addr), 0);
        check("rst_wr_addr", int'(dmWrDat_addr), 0);
        check("rst_wr_dat", int'(dmWrDat), 0);
        rst = 1'b0;

        run_xfer(1'b1, 10'd0, 10'd0, 11'd3, 16'd47, -1, 1'b0);
        for (int i = 0; i < 3; i++) check("fill47", int'(mem[i]), 47);

        mem[0] = 16'd47; mem[1] = 16'd74; mem[2] = 16'd5;
        run_xfer(1'b0, 10'd0, 10'd8, 11'd3, 16'd0, -1, 1'b0);
        check("copy_m8", int'(mem[8]), 47);
        check("copy_m9", int'(mem[9]), 74);
        check("copy_m10", int'(mem[10]), 5);

        for (int i = 0; i < 4; i++) mem[i] = 16'(i + 1);
        run_xfer(1'b0, 10'd0, 10'd1, 11'd4, 16'd0, -1, 1'b0);
        check("ovl_m0", int'(mem[0]), 1);
        for (int i = 0; i < 4; i++) check("ovl_dst", int'(mem[i + 1]), i + 1);

        mem[2] = 16'h1234;
        run_xfer(1'b1, 10'd0, 10'd1022, 11'd4, 16'd9, -1, 1'b0);
        check("wrap_m1023", int'(mem[1023]), 9);
        check("wrap_m1", int'(mem[1]), 9);
        check("wrap_m2", int'(mem[2]), 16'h1234);

        run_xfer(1'b0, 10'd5, 10'd50, 11'd0, 16'd0, -1, 1'b0);
        run_xfer(1'b1, 10'd0, 10'd300, 11'd8, 16'h00aa, -1, 1'b1);
        run_xfer(1'b1, 10'd0, 10'd400, 11'd1, 16'h00bb, -1, 1'b1);
        run_xfer(1'b0, 10'd100, 10'd200, 11'd6, 16'd0, 2, 1'b0);
        run_xfer(1'b0, 10'd100, 10'd200, 11'd6, 16'd0, -1, 1'b0);
        run_xfer(1'b0, 10'd1020, 10'd2, 11'd10, 16'd0, -1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            rm = 1'($urandom);
            rs = 10'($urandom);
            rd = ($urandom_range(0, 1) == 1) ? rs + 10'($urandom_range(0, 8)) : 10'($urandom);
            rl = 11'($urandom_range(0, 24));
            run_xfer(rm, rs, rd, rl, 16'($urandom), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_copy_engine.md
Name: dm_copy_engine

Overview:
- Initiator-side master for the DataMem port pair (dmWrDat/dmWrDat_addr/dmWrite write side; dmReDat_addr/dmReDat read side).
- Given a source base, destination base and length, it moves 16-bit words within DataMem: copy mode reads then writes each word, fill mode writes a constant.
- Sits between the control unit, or a test sequencer, and DataMem. It replaces hand-driven address and write-enable sequencing.

Parameters:
- AW, 10, DataMem address width (1024 words).
- DW, 16, DataMem data width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  AW  source base word address (ignored in fill mode).
- dst_addr  in  AW  destination base word address.
- len  in  AW+1  word count, 0..1024.
- fill_val  in  DW  fill pattern (mode=1).
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at completion.
- dmReDat  in  DW  DataMem read data; combinational from dmReDat_addr.
- dmReDat_addr  out  AW  DataMem read address.
- dmWrDat  out  DW  DataMem write data.
- dmWrDat_addr  out  AW  DataMem write address.
- dmWrite  out  1  DataMem write enable.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, dmWrite=0; dmReDat_addr=0, dmWrDat_addr=0, dmWrDat=0; internal count=0.
- All outputs are registered. dmWrite deasserts on rst assertion without waiting for clk.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - start=1 latches mode, src, dst, len and fill_val.
  - If len=0, go to FIN; no DataMem writes occur.
  - Otherwise go to RD when mode=0, or to WR when mode=1.
  - start=0 stays in IDLE.
- Direction (copy only):
  - If dst_addr > src_addr and dst_addr < src_addr+len (overlap, unwrapped compare), copy descending: first word is base+len-1, then decrement.
  - Otherwise copy ascending from base.
  - Fill mode is always ascending.
- RD (copy only):
  - dmReDat_addr holds the current source address for the whole cycle.
  - At the clock edge that ends RD, dmReDat is captured into the data buffer. Go to WR.
- WR:
  - dmWrite=1 for exactly one cycle.
  - dmWrDat_addr = current destination address; dmWrDat = buffer (copy) or fill_val (fill). Address and data are stable the entire cycle that dmWrite is high.
  - At the end of WR: count decrements and addresses step.
  - Go to FIN if count reaches 0; otherwise go to RD (copy) or stay in WR (fill). Fill therefore writes back-to-back and dmWrite stays high across words.
- Address arithmetic: modulo 2^AW. Address 1023 ascending wraps to 0; address 0 descending wraps to 1023.
- FIN: done=1 for one cycle, busy=0, dmWrite=0. Go to IDLE.
- Throughput:
  - Copy takes 2 cycles per word; done comes 2*len+1 cycles after the start edge.
  - Fill takes 1 cycle per word; done comes len+1 cycles after the start edge.
- start while busy is ignored; no queuing.
- start in the FIN cycle is ignored.
- Reset mid-transfer aborts the transfer:
  - Words already written remain.
  - No done pulse is issued.
- Outside WR, dmWrite=0. dmWrDat_addr and dmWrDat hold their last values.

Test Plan:
- Fill mode, dst=0, len=3, fill_val=47 -> dmWrite high 3 consecutive cycles at addresses 0,1,2; done pulse 4 cycles after start; DM[0..2]=47.
- Copy: preload DM[0..2]=47,74,5; src=0, dst=8, len=3 -> writes interleave with reads; DM[8..10]=47,74,5; done 7 cycles after start; busy high for 6 cycles.
- Overlap copy: DM[0..3]=1,2,3,4; src=0, dst=1, len=4 (descending) -> DM[1..4]=1,2,3,4; DM[0] unchanged at 1.
- Wrap: fill dst=1022, len=4, fill_val=9 -> writes to 1022, 1023, 0, 1; DM[2] untouched.
- len=0 with start -> no dmWrite at all; done 1 cycle later. Also: start pulse during busy -> ignored, original transfer completes unchanged.
- Reset asserted mid-copy (after 2nd write) -> dmWrite low immediately; busy=0; no done; DM holds only the first 2 copied words. A new start then runs normally.
